pulse_monitor: RTL
==================

PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter TIMEOUT, default 32'd1_000_000: maximum run length in cycles before a timeout error.
REQ-002 clk_in  input  1  sole clock, all state on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 signal_in  input  8  pulse code bus, synchronous to clk_in.
REQ-005 enable  input  1  high = monitoring active.
REQ-006 clear  input  1  single-cycle pulse; clears seq_error, err_code, seq_count.
REQ-007 rd_idx  input  4  phase index for the duration readback port.
REQ-008 locked  output  1  high while tracking a valid sequence.
REQ-009 dur_valid  output  1  one-cycle strobe; dur_out/dur_phase valid.
REQ-010 dur_out  output  32  length in cycles of the run that just ended.
REQ-011 dur_phase  output  4  phase index (0-11) of the run that just ended.
REQ-012 seq_error  output  1  sticky error flag.
REQ-013 err_code  output  2  0 none, 1 unexpected code, 2 timeout; holds first error until clear.
REQ-014 seq_count  output  16  completed 12-phase sequences, wraps 16'hFFFF->0.
REQ-015 rd_dur  output  32  last stored duration for phase rd_idx; combinational read.

Function
REQ-016 Phase code table, index 0-11: 88,80,90,80,84,80,A0,80,82,80,84,80 (hex).
REQ-017 sig_q SHALL register signal_in every cycle; an edge occurs in any cycle where signal_in != sig_q.
REQ-018 run_cnt SHALL load 1 on an edge, else increment, saturating at 32'hFFFF_FFFF.
REQ-019 States: IDLE, LOCKED; locked = (state==LOCKED).
REQ-020 IDLE->LOCKED on an edge with signal_in==8'h88 and enable high; exp_idx set to 0; no duration reported for the ended run.
REQ-021 LOCKED, on edge: the next clock SHALL drive dur_valid=1, dur_out=run_cnt, dur_phase=exp_idx, and store run_cnt into entry exp_idx of the 12x32 duration array.
REQ-022 LOCKED, on edge, new value == code[(exp_idx+1) mod 12]: exp_idx advances; 11 wraps to 0 and increments seq_count in the same cycle.
REQ-023 LOCKED, on edge, new value mismatches: report the ended run per REQ-021, set seq_error, err_code=1 if 0, go IDLE.
REQ-024 LOCKED, no edge, run_cnt == TIMEOUT: set seq_error, err_code=2 if 0, go IDLE, no dur_valid.
REQ-025 After any exit to IDLE, resync only per REQ-020; a 0x88 value already present does not relock without a new edge.
REQ-026 enable low: state forced to IDLE next cycle, dur_valid=0; sig_q, run_cnt, duration array keep operating/holding.
REQ-027 clear and an error event in the same cycle: error wins (seq_error=1, err_code=new code, seq_count cleared).
REQ-028 rd_idx 12-15 SHALL return rd_dur=0.
REQ-029 dur_valid SHALL never assert in two consecutive cycles unless edges occur in consecutive cycles.

Reset
REQ-030 rst_n_in low SHALL asynchronously set: state IDLE, locked=0, sig_q=8'h00, run_cnt=0, exp_idx=0, dur_valid=0, dur_out=0, dur_phase=0, seq_error=0, err_code=0, seq_count=0, all duration entries 0.
REQ-031 Reset mid-sequence SHALL abandon the sequence; after release, first edge into 8'h88 relocks.

Verification
REQ-032 Idle 80 for 5 cycles, then 88x11, 80x21, 90x31, 80x41, 84x51, 80x61, A0x71, 80x81, 82x91, 80x101, 84x111, 80x121, 88 -> 12 dur_valid strobes, dur_out 11,21,...,121, phases 0-11, seq_count=1, seq_error=0.
REQ-033 After REQ-032, rd_idx=4 -> rd_dur=51; rd_idx=13 -> rd_dur=0.
REQ-034 Locked, phase 1 (80) followed by 84 instead of 90 -> dur_valid with dur_phase=1, seq_error=1, err_code=1, locked=0.
REQ-035 TIMEOUT=100, locked, hold 88 for 100 cycles -> err_code=2, locked=0, no dur_valid; later 80->88 edge relocks with err_code still 2 until clear.
REQ-036 rst_n_in low for 1 cycle mid-phase 5 -> all outputs zero immediately; resumed stream relocks only at next 80->88 edge.
REQ-037 clear pulsed in same cycle as mismatch -> seq_error=1, err_code=1, seq_count=0.

Source files
------------

// File: rtl/pulse_monitor.sv
// pulse_monitor: tracks a repeating 12-phase pulse code sequence on signal_in,
// reports each phase's run length and latches the first sequence error.
module pulse_monitor #(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  signal_in,
  input  logic        enable,
  input  logic        clear,
  input  logic [3:0]  rd_idx,
  output logic        locked,
  output logic        dur_valid,
  output logic [31:0] dur_out,
  output logic [3:0]  dur_phase,
  output logic        seq_error,
  output logic [1:0]  err_code,
  output logic [15:0] seq_count,
  output logic [31:0] rd_dur
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [7:0] CODES [12] = '{8'h88, 8'h80, 8'h90, 8'h80, 8'h84, 8'h80,
                                        8'hA0, 8'h80, 8'h82, 8'h80, 8'h84, 8'h80};
  state_t      state, state_nxt;
  logic [7:0]  sig_q;
  logic [31:0] run_cnt;
  logic [3:0]  exp_idx, nxt_idx;
  logic [31:0] dur_mem [12];
  logic        edge_det, report, advance, wrap, err_mis, err_to, err_any;
  logic [1:0]  err_new;
  assign edge_det = signal_in != sig_q;
  assign nxt_idx  = exp_idx == 4'd11 ? 4'd0 : exp_idx + 4'd1;
  assign locked   = state == LOCKED;
  assign rd_dur   = rd_idx < 4'd12 ? dur_mem[rd_idx] : 32'd0;
  assign wrap     = advance && exp_idx == 4'd11;
  assign err_any  = err_mis || err_to;
  assign err_new  = err_mis ? 2'd1 : 2'd2;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else state <= state_nxt;
  end
  // Locking needs a fresh edge into 8'h88; a held 8'h88 never relocks.
  always_comb begin
    state_nxt = state;
    report    = 1'b0;
    advance   = 1'b0;
    err_mis   = 1'b0;
    err_to    = 1'b0;
    if (!enable) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = edge_det && signal_in == 8'h88 ? LOCKED : IDLE;
    else if (edge_det) begin
      report    = 1'b1;
      advance   = signal_in == CODES[nxt_idx];
      err_mis   = !advance;
      state_nxt = advance ? LOCKED : IDLE;
    end else if (run_cnt == TIMEOUT) begin
      err_to    = 1'b1;
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sig_q     <= 8'h00;
      run_cnt   <= 32'd0;
      exp_idx   <= 4'd0;
      dur_valid <= 1'b0;
      dur_out   <= 32'd0;
      dur_phase <= 4'd0;
      seq_error <= 1'b0;
      err_code  <= 2'd0;
      seq_count <= 16'd0;
      for (int i = 0; i < 12; i++) dur_mem[i] <= 32'd0;
    end else begin
      sig_q     <= signal_in;
      run_cnt   <= edge_det ? 32'd1 : run_cnt == '1 ? run_cnt : run_cnt + 32'd1;
      dur_valid <= report;
      if (report) begin
        dur_out          <= run_cnt;
        dur_phase        <= exp_idx;
        dur_mem[exp_idx] <= run_cnt;
      end
      exp_idx <= state == IDLE ? 4'd0 : advance ? nxt_idx : exp_idx;
      // An error in the same cycle as clear overrides the clear of the flags.
      if (err_any) begin
        seq_error <= 1'b1;
        err_code  <= err_code == 2'd0 || clear ? err_new : err_code;
      end else if (clear) begin
        seq_error <= 1'b0;
        err_code  <= 2'd0;
      end
      seq_count <= clear ? 16'd0 : seq_count + {15'd0, wrap};
    end
  end
endmodule
